virtual_wire_cmd_bridge: RTL

Consumes the host-driven source word of a JTAG virtual wire and turns each host command into one register-bus transaction in the rx_clk domain. It debounces multi-bit source updates, issues a valid/ready command, waits for the response and returns status and read data on the probe word read back by the host. It sits directly downstream of the virtual wire's source output, and its probe output feeds that same wire's probe input.

---
 rtl/virtual_wire_cmd_bridge.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/virtual_wire_cmd_bridge.sv
// Bridges a host-driven virtual-wire source word to a valid/ready register-bus command.
// The status and read data go back to the host on the registered probe word.
module virtual_wire_cmd_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SW = ADDR_WIDTH + DATA_WIDTH + 2,
  localparam int PW = DATA_WIDTH + 3
) (
  input  logic                  rx_clk,
  input  logic                  rx_reset_n,
  input  logic [SW-1:0]         rx_source,
  output logic [PW-1:0]         tx_probe,
  output logic                  tx_cmd_valid,
  input  logic                  rx_cmd_ready,
  output logic                  tx_cmd_write,
  output logic [ADDR_WIDTH-1:0] tx_cmd_addr,
  output logic [DATA_WIDTH-1:0] tx_cmd_wdata,
  input  logic                  rx_rsp_valid,
  input  logic [DATA_WIDTH-1:0] rx_rsp_rdata
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, ISSUE, WAIT_RESP, DONE} state_t;

  state_t                state, state_n;
  logic [SW-1:0]         src_q, snap;
  logic [CW-1:0]         cnt;
  logic [TW-1:0]         tmo;
  logic                  ack_seq, busy, err, err_n;
  logic [DATA_WIDTH-1:0] rdata, rdata_n;

  logic snap_load, cnt_clr, cnt_inc, tmo_clr, tmo_inc;
  logic busy_set, busy_clr, rsp_take, tmo_fire, done;

  assign tx_probe     = {ack_seq, busy, err, rdata};
  assign tx_cmd_valid = (state == ISSUE);
  assign tx_cmd_write = snap[SW-2];
  assign tx_cmd_addr  = snap[SW-3 -: ADDR_WIDTH];
  assign tx_cmd_wdata = snap[DATA_WIDTH-1:0];

  always_ff @(posedge rx_clk or negedge rx_reset_n) begin
    if (!rx_reset_n) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n   = state;
    snap_load = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;
    rsp_take  = 1'b0;
    tmo_fire  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (src_q[SW-1] != ack_seq) begin
          state_n   = SETTLE;
          snap_load = 1'b1;
          cnt_clr   = 1'b1;
          busy_set  = 1'b1;
        end
      end
      SETTLE: begin
        if (src_q != snap) begin
          // A changed word whose seq matches ack_seq means the host withdrew the command
          if (src_q[SW-1] == ack_seq) begin
            state_n  = IDLE;
            busy_clr = 1'b1;
          end else begin
            snap_load = 1'b1;
            cnt_clr   = 1'b1;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = ISSUE;
          tmo_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ISSUE: begin
        tmo_inc = 1'b1;
        if (rx_cmd_ready) begin
          if (rx_rsp_valid) begin
            state_n  = DONE;
            rsp_take = 1'b1;
          end else begin
            state_n = WAIT_RESP;
          end
        end else if (tmo == TMO_LAST) begin
          state_n  = DONE;
          tmo_fire = 1'b1;
        end
      end
      WAIT_RESP: begin
        tmo_inc = 1'b1;
        if (rx_rsp_valid) begin
          state_n  = DONE;
          rsp_take = 1'b1;
        end else if (tmo == TMO_LAST) begin
          state_n  = DONE;
          tmo_fire = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        done    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      src_q   <= '0;
      snap    <= '0;
      cnt     <= '0;
      tmo     <= '0;
      ack_seq <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      err_n   <= 1'b0;
      rdata   <= '0;
      rdata_n <= '0;
    end else begin
      src_q <= rx_source;
      if (snap_load) snap <= src_q;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (tmo_clr)      tmo <= '0;
      else if (tmo_inc) tmo <= tmo + 1'b1;
      if (busy_set) busy <= 1'b1;
      if (busy_clr) busy <= 1'b0;
      if (rsp_take) begin
        rdata_n <= snap[SW-2] ? '0 : rx_rsp_rdata;
        err_n   <= 1'b0;
      end
      if (tmo_fire) begin
        rdata_n <= '0;
        err_n   <= 1'b1;
      end
      // Whole status word changes on one edge so the host never reads a torn result
      if (done) begin
        rdata   <= rdata_n;
        err     <= err_n;
        ack_seq <= snap[SW-1];
        busy    <= 1'b0;
      end
    end
  end

endmodule
